// File: rtl/program_loader.sv
// Serial program loader: assembles UART bytes into instruction words, writes the text RAM,
// and holds the processor in reset until a frame with a valid checksum has been loaded.
module program_loader #(
    parameter int        ADDR_WIDTH     = 8,
    parameter int        DATA_WIDTH     = 12,
    parameter logic [7:0] START_BYTE    = 8'hA5,
    parameter int        TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  program_write,
    output logic [ADDR_WIDTH-1:0] program_addr,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_ERROR
    } state_t;

    state_t                  state, next_state;
    logic [TW-1:0]           timer;
    logic [7:0]              remaining;
    logic [7:0]              csum;
    logic [DATA_WIDTH-9:0]   hi_bits;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    in_frame;
    logic                    is_start;
    logic                    timeout;

    assign in_frame = (state == S_LEN) || (state == S_HI) || (state == S_LO) || (state == S_CSUM);
    assign is_start = rx_valid && (rx_data == START_BYTE);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout  = in_frame && !rx_valid && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_ERROR: if (is_start) next_state = S_LEN;
            S_LEN:  if (rx_valid) next_state = (rx_data == 8'h00) ? S_ERROR : S_HI;
            S_HI:   if (rx_valid) next_state = S_LO;
            S_LO:   if (rx_valid) next_state = (remaining == 8'd1) ? S_CSUM : S_HI;
            S_CSUM: if (rx_valid) next_state = (rx_data == csum) ? S_IDLE : S_ERROR;
            default: next_state = S_IDLE;
        endcase
        if (timeout) next_state = S_ERROR;
    end

    // Status flags are registered from the next state so they move with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            error    <= 1'b0;
        end else begin
            busy     <= (next_state == S_LEN) || (next_state == S_HI) ||
                        (next_state == S_LO)  || (next_state == S_CSUM);
            cpu_hold <= (next_state != S_IDLE);
            error    <= (next_state == S_ERROR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer         <= '0;
            remaining     <= '0;
            csum          <= '0;
            hi_bits       <= '0;
            next_addr     <= '0;
            program_write <= 1'b0;
            program_addr  <= '0;
            program_cmd   <= '0;
            words_loaded  <= '0;
        end else begin
            program_write <= 1'b0;
            if (in_frame && !rx_valid) timer <= timer + 1'b1;
            else                       timer <= '0;

            if (rx_valid) begin
                case (state)
                    S_IDLE, S_ERROR: begin
                        if (is_start) begin
                            csum         <= '0;
                            next_addr    <= '0;
                            program_addr <= '0;
                            words_loaded <= '0;
                        end
                    end
                    S_LEN: begin
                        remaining <= rx_data;
                        csum      <= csum ^ rx_data;
                    end
                    S_HI: begin
                        hi_bits <= rx_data[DATA_WIDTH-9:0];
                        csum    <= csum ^ rx_data;
                    end
                    S_LO: begin
                        csum          <= csum ^ rx_data;
                        program_cmd   <= {hi_bits, rx_data};
                        program_addr  <= next_addr;
                        next_addr     <= next_addr + 1'b1;
                        program_write <= 1'b1;
                        remaining     <= remaining - 8'd1;
                        words_loaded  <= words_loaded + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal load, checksum/length/timeout errors,
// noise and in-frame start bytes, and reset in the middle of a frame.
module tb_program_loader;

    localparam int AW = 8;
    localparam int DW = 12;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          program_write;
    logic [AW-1:0] program_addr;
    logic [DW-1:0] program_cmd;
    logic          cpu_hold;
    logic          busy;
    logic          error;
    logic [AW-1:0] words_loaded;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    int wr_base;

    program_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .program_write(program_write), .program_addr(program_addr), .program_cmd(program_cmd),
        .cpu_hold(cpu_hold), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Counts write pulses as seen just before each rising edge.
    always @(posedge clk) if (program_write) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was sampled.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk("rst_write", program_write, 0);
        chk("rst_addr", program_addr, 0);
        chk("rst_cmd", program_cmd, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b0;
        idle(1);

        // Noise in IDLE
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("noise_busy", busy, 0);
        chk("noise_hold", cpu_hold, 0);
        chk("noise_wr", wr_count, 0);

        // Nominal frame
        send(8'hA5);
        chk("nom_hold_up", cpu_hold, 1);
        chk("nom_busy", busy, 1);
        send(8'h02); send(8'h01); send(8'h23);
        chk("nom_w0_pulse", program_write, 1);
        chk("nom_w0_addr", program_addr, 0);
        chk("nom_w0_cmd", program_cmd, 12'h123);
        send(8'h0F);
        chk("nom_pulse_end", program_write, 0);
        chk("nom_addr_hold", program_addr, 0);
        send(8'h45);
        chk("nom_w1_pulse", program_write, 1);
        chk("nom_w1_addr", program_addr, 1);
        chk("nom_w1_cmd", program_cmd, 12'hF45);
        chk("nom_hold_pre", cpu_hold, 1);
        send(8'h6A);
        chk("nom_hold_down", cpu_hold, 0);
        chk("nom_busy_end", busy, 0);
        chk("nom_error", error, 0);
        chk("nom_words", words_loaded, 2);
        chk("nom_wr", wr_count, 2);

        // Bad checksum, then recovery
        wr_base = wr_count;
        send(8'hA5); send(8'h02); send(8'h01); send(8'h23); send(8'h0F); send(8'h45); send(8'h00);
        chk("bad_error", error, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_busy", busy, 0);
        chk("bad_words", words_loaded, 2);
        chk("bad_wr", wr_count - wr_base, 2);
        send(8'h6A);
        chk("err_ignore", error, 1);
        send(8'hA5);
        chk("rec_err_clr", error, 0);
        chk("rec_words_clr", words_loaded, 0);
        send(8'h02); send(8'h01); send(8'h23); send(8'h0F); send(8'h45); send(8'h6A);
        chk("rec_hold", cpu_hold, 0);
        chk("rec_error", error, 0);

        // Zero length
        wr_base = wr_count;
        send(8'hA5); send(8'h00);
        chk("zero_error", error, 1);
        chk("zero_hold", cpu_hold, 1);
        chk("zero_busy", busy, 0);
        idle(1);
        chk("zero_wr", wr_count - wr_base, 0);

        // Timeout
        wr_base = wr_count;
        send(8'hA5); send(8'h01); send(8'h10);
        idle(TO - 1);
        chk("to_before", error, 0);
        chk("to_busy_before", busy, 1);
        idle(1);
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_wr", wr_count - wr_base, 0);

        // Byte on the expiry cycle is accepted
        send(8'hA5); send(8'h01); send(8'h10);
        idle(TO - 1);
        send(8'h20);
        chk("edge_pulse", program_write, 1);
        chk("edge_cmd", program_cmd, 12'h020);
        chk("edge_error", error, 0);
        send(8'h31);
        chk("edge_hold", cpu_hold, 0);
        chk("edge_err_end", error, 0);

        // Start marker as data
        send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5);
        chk("mid_pulse", program_write, 1);
        chk("mid_addr", program_addr, 0);
        chk("mid_cmd", program_cmd, 12'h5A5);
        send(8'h01);
        chk("mid_hold", cpu_hold, 0);
        chk("mid_error", error, 0);
        chk("mid_words", words_loaded, 1);

        // Reset one cycle after a LO strobe
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34);
        chk("rm_pulse", program_write, 1);
        chk("rm_cmd_pre", program_cmd, 12'h234);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rm_write", program_write, 0);
        chk("rm_addr", program_addr, 0);
        chk("rm_cmd", program_cmd, 0);
        chk("rm_hold", cpu_hold, 0);
        chk("rm_busy", busy, 0);
        chk("rm_error", error, 0);
        chk("rm_words", words_loaded, 0);
        wr_base = wr_count;
        send(8'h56); send(8'h78);
        idle(1);
        chk("rm_idle_busy", busy, 0);
        chk("rm_idle_wr", wr_count - wr_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
